// File: rtl/e203_plic_claim_mstr.sv
// ---------------------------------------------------------------------------
// e203_plic_claim_mstr
//
// Hardware claim/complete initiator for the PLIC, on the hart side of the
// external interrupt line. When ext_irq is pending and en is set it reads the
// PLIC claim register over ICB. It then hands the claimed source ID to a
// consumer through a valid/ready handshake. When the consumer pulses done,
// it writes the same ID back to the complete register.
//
// Optional build macro: E203_PLIC_CLAIM_TMO_EN
//   When defined, a response watchdog aborts a *_RSP wait after TMO_CYC
//   cycles. It also keeps icb_rsp_ready high in IDLE so that late responses
//   are drained.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   en                allows new claims to start
//   ext_irq           PLIC external interrupt (level)
//   icb_cmd_*         ICB command channel (read = claim, write = complete)
//   icb_rsp_*         ICB response channel
//   id_valid/id_ready claimed-ID handshake to the consumer; id holds the ID
//   done              consumer pulse: servicing finished, issue complete
//   busy              FSM not in IDLE
//   spur_cnt          saturating count of spurious claims
//   err               one-cycle pulse on ICB response error (or timeout)
// ---------------------------------------------------------------------------
module e203_plic_claim_mstr #(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DW         = 32,
    parameter int unsigned          ID_W       = 5,
    parameter int unsigned          NUM_SRC    = 16,
    parameter logic [ADDR_W-1:0]    CLAIM_ADDR = 32'h0C20_0004,
    parameter int unsigned          TMO_CYC    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                ext_irq,
    output logic                icb_cmd_valid,
    input  logic                icb_cmd_ready,
    output logic [ADDR_W-1:0]   icb_cmd_addr,
    output logic                icb_cmd_read,
    output logic [DW-1:0]       icb_cmd_wdata,
    output logic [DW/8-1:0]     icb_cmd_wmask,
    input  logic                icb_rsp_valid,
    output logic                icb_rsp_ready,
    input  logic                icb_rsp_err,
    input  logic [DW-1:0]       icb_rsp_rdata,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [ID_W-1:0]     id,
    input  logic                done,
    output logic                busy,
    output logic [7:0]          spur_cnt,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE, CLM_CMD, CLM_RSP, DELIV, WAIT_DONE, CMP_CMD, CMP_RSP
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] id_q;
    logic [7:0]      spur_q;
    logic            err_q;
    logic            in_rsp;
    logic            tmo_hit;
    logic [ID_W-1:0] rsp_id;
    logic            rsp_spur;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_rsp = (state == CLM_RSP) || (state == CMP_RSP);
    assign rsp_id = icb_rsp_rdata[ID_W-1:0];
    // The claim value is spurious if it is the reserved ID 0, lies beyond the
    // implemented sources, or has stray upper bits set.
    assign rsp_spur = (rsp_id == '0) || (32'(rsp_id) > NUM_SRC) ||
                      (icb_rsp_rdata[DW-1:ID_W] != '0);

`ifdef E203_PLIC_CLAIM_TMO_EN
    localparam logic [7:0] TMO_LIM = TMO_CYC[7:0];
    logic [7:0] tmo_cnt;

    assign tmo_hit = in_rsp && !icb_rsp_valid && ((tmo_cnt + 8'd1) == TMO_LIM);

    // Held at zero outside the response states, so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst || !in_rsp || tmo_hit)
            tmo_cnt <= 8'd0;
        else if (!icb_rsp_valid)
            tmo_cnt <= tmo_cnt + 8'd1;
    end
`else
    localparam logic [7:0] TMO_LIM = TMO_CYC[7:0];
    logic unused_tmo;
    assign unused_tmo = ^TMO_LIM;
    assign tmo_hit    = 1'b0;
`endif

    // State register plus the small amount of datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            id_q   <= '0;
            spur_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (in_rsp && icb_rsp_valid && icb_rsp_err) || tmo_hit;
            if (state == CLM_RSP && icb_rsp_valid) begin
                id_q <= rsp_id;
                if (!icb_rsp_err && rsp_spur)
                    spur_q <= sat_inc8(spur_q);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (en && ext_irq)  state_nxt = CLM_CMD;
            CLM_CMD:   if (icb_cmd_ready)  state_nxt = CLM_RSP;
            CLM_RSP: begin
                if (icb_rsp_valid)
                    state_nxt = (icb_rsp_err || rsp_spur) ? IDLE : DELIV;
                else if (tmo_hit)
                    state_nxt = IDLE;
            end
            DELIV:     if (id_ready)       state_nxt = WAIT_DONE;
            WAIT_DONE: if (done)           state_nxt = CMP_CMD;
            CMP_CMD:   if (icb_cmd_ready)  state_nxt = CMP_RSP;
            CMP_RSP:   if (icb_rsp_valid || tmo_hit) state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Output decode; everything is a function of registered state only.
    always_comb begin
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b0;
        id_valid      = 1'b0;
        case (state)
            CLM_CMD: begin
                icb_cmd_valid = 1'b1;
                icb_cmd_read  = 1'b1;
            end
            CMP_CMD: begin
                icb_cmd_valid = 1'b1;
                icb_cmd_wdata = {{(DW-ID_W){1'b0}}, id_q};
                icb_cmd_wmask = '1;
            end
            CLM_RSP, CMP_RSP: icb_rsp_ready = 1'b1;
            DELIV:            id_valid      = 1'b1;
`ifdef E203_PLIC_CLAIM_TMO_EN
            IDLE:             icb_rsp_ready = 1'b1;
`endif
            default: ;
        endcase
    end

    assign icb_cmd_addr = CLAIM_ADDR;
    assign id           = id_q;
    assign busy         = (state != IDLE);
    assign spur_cnt     = spur_q;
    assign err          = err_q;

endmodule

// File: tb/tb_e203_plic_claim_mstr.sv
// ---------------------------------------------------------------------------
// tb_e203_plic_claim_mstr
//
// Directed bench for e203_plic_claim_mstr. The ICB slave is modelled by
// inputs that the stimulus thread holds at fixed values. A passive monitor
// counts command handshakes, ID handshakes and err cycles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_e203_plic_claim_mstr;

    logic        clk = 1'b0;
    logic        rst, en, ext_irq;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        id_valid, id_ready, done, busy, err;
    logic [4:0]  id;
    logic [7:0]  spur_cnt;

    int total = 0;
    int bad   = 0;
    int cnt_rd = 0, cnt_wr = 0, cnt_idh = 0, cnt_err = 0;
    int rd0, wr0, idh0, err0;

    always #5 clk = ~clk;

    e203_plic_claim_mstr #(.TMO_CYC(10)) dut (
        .clk(clk), .rst(rst), .en(en), .ext_irq(ext_irq),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id(id),
        .done(done), .busy(busy), .spur_cnt(spur_cnt), .err(err)
    );

    always @(posedge clk) begin
        if (icb_cmd_valid && icb_cmd_ready) begin
            if (icb_cmd_read) cnt_rd <= cnt_rd + 1;
            else              cnt_wr <= cnt_wr + 1;
        end
        if (id_valid && id_ready) cnt_idh <= cnt_idh + 1;
        if (err)                  cnt_err <= cnt_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One claim with zero-wait ICB. It ends in IDLE for a rejected claim,
    // or in DELIV for a valid one.
    task automatic claim(input logic [31:0] rdata);
        icb_rsp_rdata = rdata;
        ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ext_irq = 1'b0; icb_cmd_ready = 1'b1;
        icb_rsp_valid = 1'b1; icb_rsp_err = 1'b0; icb_rsp_rdata = '0;
        id_ready = 1'b0; done = 1'b0;
        repeat (3) step();
        chk("rst_cmd_valid", icb_cmd_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id", id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spur", spur_cnt, 0);
        chk("rst_err", err, 0);
`ifndef E203_PLIC_CLAIM_TMO_EN
        chk("rst_rsp_ready", icb_rsp_ready, 0);
`endif
        rst = 1'b0;
        step();

        // Claim of ID 7 with zero-wait ICB; consumer ready later.
        en = 1'b1; icb_rsp_rdata = 32'h7; ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        chk("c1_cmd_valid", icb_cmd_valid, 1);
        chk("c1_cmd_read", icb_cmd_read, 1);
        chk("c1_cmd_addr", icb_cmd_addr, 32'h0C20_0004);
        chk("c1_wmask_rd", icb_cmd_wmask, 0);
        chk("c1_idv_early1", id_valid, 0);
        step();
        chk("c1_idv_early2", id_valid, 0);
        chk("c1_rsp_ready", icb_rsp_ready, 1);
        step();
        chk("c1_id_valid", id_valid, 1);
        chk("c1_id", id, 7);
        step();
        chk("c1_id_hold", id_valid, 1);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("c1_idv_drop", id_valid, 0);
        chk("c1_busy_wait", busy, 1);
        step(); step();
        chk("c1_no_early_wr", cnt_wr, 0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("c1_wr_valid", icb_cmd_valid, 1);
        chk("c1_wr_read", icb_cmd_read, 0);
        chk("c1_wr_wdata", icb_cmd_wdata, 32'h7);
        chk("c1_wr_wmask", icb_cmd_wmask, 4'hF);
        chk("c1_wr_addr", icb_cmd_addr, 32'h0C20_0004);
        step();
        chk("c1_busy_rsp", busy, 1);
        step();
        chk("c1_busy_end", busy, 0);
        chk("c1_rd_cnt", cnt_rd, 1);
        chk("c1_wr_cnt", cnt_wr, 1);
        chk("c1_idh_cnt", cnt_idh, 1);

        // Spurious claims: zero ID, ID above NUM_SRC, stray upper bits.
        claim(32'h0);
        chk("sp0_cnt", spur_cnt, 1);
        chk("sp0_busy", busy, 0);
        claim(32'd17);
        chk("sp17_cnt", spur_cnt, 2);
        claim(32'h23);
        chk("sp_hi_cnt", spur_cnt, 3);
        chk("sp_no_idh", cnt_idh, 1);
        chk("sp_no_wr", cnt_wr, 1);

        // ID 16 is the highest valid source and must be delivered.
        claim(32'd16);
        chk("id16_valid", id_valid, 1);
        chk("id16_id", id, 16);
        id_ready = 1'b1; step(); id_ready = 1'b0;
        done = 1'b1; step(); done = 1'b0;
        chk("id16_wdata", icb_cmd_wdata, 32'd16);
        step(); step();
        chk("id16_end", busy, 0);

        // Saturation of the spurious counter.
        for (int i = 0; i < 300; i++) begin
            claim(32'h0);
            if (i == 250) chk("sat_254", spur_cnt, 254);
            if (i == 251) chk("sat_255", spur_cnt, 255);
        end
        chk("sat_hold", spur_cnt, 255);

        // Back-to-back: ext_irq still high on return to IDLE.
        ext_irq = 1'b1; icb_rsp_rdata = 32'h0;
        step(); step(); step();
        step();
        ext_irq = 1'b0;
        chk("b2b_cmd", icb_cmd_valid, 1);
        step(); step();
        chk("b2b_end", busy, 0);

        // Command stalls on both claim and complete.
        rd0 = cnt_rd; wr0 = cnt_wr;
        icb_cmd_ready = 1'b0; icb_rsp_rdata = 32'h5; ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stl_c_valid", icb_cmd_valid, 1);
            chk("stl_c_read", icb_cmd_read, 1);
            chk("stl_c_addr", icb_cmd_addr, 32'h0C20_0004);
            step();
        end
        icb_cmd_ready = 1'b1;
        step(); step();
        chk("stl_id", id, 5);
        id_ready = 1'b1; step(); id_ready = 1'b0;
        icb_cmd_ready = 1'b0;
        done = 1'b1; step(); done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stl_w_valid", icb_cmd_valid, 1);
            chk("stl_w_read", icb_cmd_read, 0);
            chk("stl_w_wdata", icb_cmd_wdata, 32'h5);
            step();
        end
        icb_cmd_ready = 1'b1;
        step(); step();
        chk("stl_end", busy, 0);
        chk("stl_rd_once", cnt_rd - rd0, 1);
        chk("stl_wr_once", cnt_wr - wr0, 1);

        // Claim response error.
        idh0 = cnt_idh; wr0 = cnt_wr; err0 = cnt_err;
        icb_rsp_err = 1'b1;
        claim(32'h9);
        icb_rsp_err = 1'b0;
        chk("er_pulse", err, 1);
        chk("er_busy", busy, 0);
        step();
        chk("er_pulse_end", err, 0);
        chk("er_len", cnt_err - err0, 1);
        chk("er_no_idh", cnt_idh - idh0, 0);
        chk("er_no_wr", cnt_wr - wr0, 0);

        // en gating, done ignored in IDLE, en dropped mid-sequence.
        en = 1'b0; ext_irq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en0_no_cmd", icb_cmd_valid, 0);
        end
        ext_irq = 1'b0; en = 1'b1;
        done = 1'b1; step(); done = 1'b0;
        chk("done_idle", busy, 0);
        wr0 = cnt_wr;
        claim(32'h3);
        id_ready = 1'b1; step(); id_ready = 1'b0;
        en = 1'b0;
        step(); step();
        done = 1'b1; step(); done = 1'b0;
        chk("en_drop_wr", icb_cmd_valid, 1);
        chk("en_drop_wdata", icb_cmd_wdata, 32'h3);
        step(); step();
        chk("en_drop_end", busy, 0);
        chk("en_drop_wrcnt", cnt_wr - wr0, 1);
        en = 1'b1;

        // Missing claim response.
        err0 = cnt_err;
        icb_rsp_valid = 1'b0;
        ext_irq = 1'b1; step(); ext_irq = 1'b0;
        step();
`ifdef E203_PLIC_CLAIM_TMO_EN
        for (int i = 0; i < 9; i++) begin
            step();
            chk("tmo_wait", busy, 1);
        end
        step();
        chk("tmo_err", err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_rdy_idle", icb_rsp_ready, 1);
        step();
        chk("tmo_err_end", err, 0);
        icb_rsp_rdata = 32'h7; icb_rsp_valid = 1'b1;
        step();
        chk("tmo_late_drop", busy, 0);
        chk("tmo_late_idv", id_valid, 0);
`else
        repeat (1000) step();
        chk("ntmo_busy", busy, 1);
        chk("ntmo_rdy", icb_rsp_ready, 1);
        chk("ntmo_no_err", cnt_err - err0, 0);
        icb_rsp_rdata = 32'h0; icb_rsp_valid = 1'b1;
        step();
        chk("ntmo_end", busy, 0);
`endif

        // Reset in the middle of a delivery.
        claim(32'h4);
        chk("mr_pre", id_valid, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mr_idv", id_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_id", id, 0);
        chk("mr_spur", spur_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
